// File: rtl/astra_bist_ctrl.sv
// March-test BIST sequencer for a small synchronous RAM.
// Runs a six-element transparent march. Every read is summed into a
// signature, and that signature is compared against the fault-free value
// when the run finishes.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; RAM interface quiet, ADDRESS parked at 0
// INIT  | signature/elem/ADDRESS cleared, RAM read set up
// RD    | read cycle; OUT accumulated into signature at closing edge
// WR    | write back the complement of the value just read
// DONE  | one-cycle done pulse; success evaluated on exit
module astra_bist_ctrl #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 3,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              in_clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              success,
   output logic [DATA_W-1:0] signature,
   output logic [2:0]        elem,
   output logic [ADDR_W-1:0] ADDRESS,
   output logic [DATA_W-1:0] DATA,
   input  logic [DATA_W-1:0] OUT,
   output logic              CS,
   output logic              WE,
   output logic              OE
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   // Sum of all fault-free reads: each word contributes 3*(v + ~v) = -3.
   localparam logic [DATA_W-1:0] SIG_EXP   = DATA_W'(-(3 * DEPTH));
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                success_q, success_d;
   logic [DATA_W-1:0]   sig_q, sig_d;
   logic [2:0]          elem_q, elem_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                cs_q, cs_d;
   logic                we_q, we_d;
   logic                oe_q, oe_d;

   logic                asc;
   logic                at_last;
   logic [ADDR_W-1:0]   addr_step;
   logic [DATA_W-1:0]   feed;

   // Address walk helpers: M0..M2 ascend, M3..M5 descend; M0 sums the complement.
   always_comb begin
      asc       = (elem_q < 3'd3);
      at_last   = asc ? (addr_q == ADDR_LAST) : (addr_q == '0);
      addr_step = asc ? (addr_q + ADDR_W'(1)) : (addr_q - ADDR_W'(1));
      feed      = (elem_q == 3'd0) ? ~OUT : OUT;
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      success_d = success_q;
      sig_d     = sig_q;
      elem_d    = elem_q;
      addr_d    = addr_q;
      data_d    = '0;
      cs_d      = 1'b0;
      we_d      = 1'b0;
      oe_d      = 1'b0;

      case (state_q)
         IDLE: begin
            addr_d = '0;
            busy_d = 1'b0;
            if (start) begin
               state_d   = INIT;
               busy_d    = 1'b1;
               success_d = 1'b0;
               sig_d     = '0;
               elem_d    = 3'd0;
            end
         end
         INIT: begin
            state_d = RD;
            cs_d    = 1'b1;
            oe_d    = 1'b1;
         end
         RD, WR: begin
            if (state_q == RD) begin
               sig_d = sig_q + feed;
            end
            if (state_q == RD && elem_q != 3'd0 && elem_q != 3'd5) begin
               // Same address is written next with the complement of this read.
               state_d = WR;
               cs_d    = 1'b1;
               we_d    = 1'b1;
               data_d  = ~OUT;
            end else if (at_last && elem_q == 3'd5) begin
               state_d = DONE;
               done_d  = 1'b1;
               addr_d  = '0;
            end else begin
               state_d = RD;
               cs_d    = 1'b1;
               oe_d    = 1'b1;
               if (at_last) begin
                  elem_d = elem_q + 3'd1;
                  addr_d = (elem_q < 3'd2) ? '0 : ADDR_LAST;
               end else begin
                  addr_d = addr_step;
               end
            end
         end
         DONE: begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            addr_d    = '0;
            success_d = (sig_q == SIG_EXP);
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            addr_d  = '0;
         end
      endcase

      // Abort wins over everything, including the final read of M5.
      if (abort && state_q != IDLE) begin
         state_d   = IDLE;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         success_d = 1'b0;
         sig_d     = sig_q;
         elem_d    = elem_q;
         addr_d    = '0;
         data_d    = '0;
         cs_d      = 1'b0;
         we_d      = 1'b0;
         oe_d      = 1'b0;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         success_q <= 1'b0;
         sig_q     <= '0;
         elem_q    <= 3'd0;
         addr_q    <= '0;
         data_q    <= '0;
         cs_q      <= 1'b0;
         we_q      <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         success_q <= success_d;
         sig_q     <= sig_d;
         elem_q    <= elem_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cs_q      <= cs_d;
         we_q      <= we_d;
         oe_q      <= oe_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign success   = success_q;
   assign signature = sig_q;
   assign elem      = elem_q;
   assign ADDRESS   = addr_q;
   assign DATA      = data_q;
   assign CS        = cs_q;
   assign WE        = we_q;
   assign OE        = oe_q;

endmodule

// File: tb/tb_astra_bist_ctrl.sv
// Directed bench for astra_bist_ctrl: a full-depth instance plus a DEPTH=3
// instance, each attached to a small behavioural RAM.
module tb_astra_bist_ctrl;

   logic in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   logic       reset_n, start, abort;
   logic       busy, done, success, cs, we, oe;
   logic [2:0] signature, elem, data, ram_out;
   logic [1:0] addr;

   logic       start2, abort2;
   logic       busy2, done2, success2, cs2, we2, oe2;
   logic [2:0] signature2, elem2, data2, ram_out2;
   logic [1:0] addr2;

   int total = 0;
   int bad   = 0;

   logic [2:0] mem  [4];
   logic [2:0] mem2 [3];
   logic       stuck_en;

   astra_bist_ctrl dut (
      .in_clk(in_clk), .reset_n(reset_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .success(success), .signature(signature),
      .elem(elem), .ADDRESS(addr), .DATA(data), .OUT(ram_out),
      .CS(cs), .WE(we), .OE(oe)
   );

   astra_bist_ctrl #(.ADDR_W(2), .DATA_W(3), .DEPTH(3)) dut2 (
      .in_clk(in_clk), .reset_n(reset_n), .start(start2), .abort(abort2),
      .busy(busy2), .done(done2), .success(success2), .signature(signature2),
      .elem(elem2), .ADDRESS(addr2), .DATA(data2), .OUT(ram_out2),
      .CS(cs2), .WE(we2), .OE(oe2)
   );

   // RAM models: combinational read, clocked write; word1 bit0 optionally stuck-at-0.
   assign ram_out  = (cs && oe) ? mem[addr] : 3'd0;
   assign ram_out2 = (cs2 && oe2 && addr2 < 2'd3) ? mem2[addr2] : 3'd0;

   always @(posedge in_clk) begin
      if (cs && we) mem[addr] <= (stuck_en && addr == 2'd1) ? (data & 3'b110) : data;
      if (cs2 && we2 && addr2 < 2'd3) mem2[addr2] <= data2;
   end

   task automatic load_mem();
      mem[0] = 3'd5; mem[1] = 3'd2; mem[2] = 3'd7; mem[3] = 3'd0;
   endtask

   // Pulses start, then samples each cycle (at negedge) up to cycle 'limit'.
   task automatic run_a(input int limit, output int dcyc, output int dcnt);
      dcyc = -1;
      dcnt = 0;
      @(negedge in_clk); start = 1'b1;
      @(negedge in_clk); start = 1'b0;
      for (int c = 1; c <= limit; c++) begin
         if (done === 1'b1) begin
            dcnt++;
            if (dcyc < 0) dcyc = c;
         end
         if (c < limit) @(negedge in_clk);
      end
   endtask

   task automatic test_reset();
      #1;
      total++; if ({busy, done, success, cs, we, oe} !== 6'b0) begin bad++;
         $display("FAIL reset_ctrl got=%b want=000000", {busy, done, success, cs, we, oe}); end
      total++; if (signature !== 3'd0) begin bad++; $display("FAIL reset_sig got=%0d want=0", signature); end
      total++; if (elem !== 3'd0) begin bad++; $display("FAIL reset_elem got=%0d want=0", elem); end
      total++; if (addr !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", addr); end
      total++; if (data !== 3'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", data); end
      @(negedge in_clk); reset_n = 1'b1;
      repeat (3) @(negedge in_clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_no_autostart busy=%b want=0", busy); end
   endtask

   task automatic test_stuck_at();
      int dcyc, dcnt;
      load_mem();
      stuck_en = 1'b1;
      run_a(43, dcyc, dcnt);
      total++; if (dcyc != 42) begin bad++; $display("FAIL stuck_done_cycle got=%0d want=42", dcyc); end
      total++; if (signature !== 3'b010) begin bad++; $display("FAIL stuck_sig got=%b want=010", signature); end
      total++; if (success !== 1'b0) begin bad++; $display("FAIL stuck_success got=%b want=0", success); end
      stuck_en = 1'b0;
   endtask

   task automatic test_full_run();
      int dcyc, dcnt;
      load_mem();
      run_a(43, dcyc, dcnt);
      total++; if (dcyc != 42) begin bad++; $display("FAIL full_done_cycle got=%0d want=42", dcyc); end
      total++; if (dcnt != 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", dcnt); end
      total++; if (signature !== 3'b100) begin bad++; $display("FAIL full_sig got=%b want=100", signature); end
      total++; if (success !== 1'b1) begin bad++; $display("FAIL full_success got=%b want=1", success); end
      total++; if ({busy, cs, we, oe} !== 4'b0 || addr !== 2'd0) begin bad++;
         $display("FAIL full_idle got busy/cs/we/oe=%b addr=%0d want=0000 0", {busy, cs, we, oe}, addr); end
      total++; if (mem[0] !== 3'd5 || mem[1] !== 3'd2 || mem[2] !== 3'd7 || mem[3] !== 3'd0) begin bad++;
         $display("FAIL full_restore got=%0d,%0d,%0d,%0d want=5,2,7,0", mem[0], mem[1], mem[2], mem[3]); end
   endtask

   task automatic test_partial_depth();
      int dcyc, bad_addr;
      dcyc = -1; bad_addr = 0;
      mem2[0] = 3'd1; mem2[1] = 3'd6; mem2[2] = 3'd3;
      @(negedge in_clk); start2 = 1'b1;
      @(negedge in_clk); start2 = 1'b0;
      for (int c = 1; c <= 33; c++) begin
         if (addr2 == 2'd3) bad_addr++;
         if (done2 === 1'b1 && dcyc < 0) dcyc = c;
         if (c < 33) @(negedge in_clk);
      end
      total++; if (bad_addr != 0) begin bad++; $display("FAIL part_addr3 got=%0d cycles want=0", bad_addr); end
      total++; if (dcyc != 32) begin bad++; $display("FAIL part_done_cycle got=%0d want=32", dcyc); end
      total++; if (signature2 !== 3'b111) begin bad++; $display("FAIL part_sig got=%b want=111", signature2); end
      total++; if (success2 !== 1'b1) begin bad++; $display("FAIL part_success got=%b want=1", success2); end
      total++; if (mem2[0] !== 3'd1 || mem2[1] !== 3'd6 || mem2[2] !== 3'd3) begin bad++;
         $display("FAIL part_restore got=%0d,%0d,%0d want=1,6,3", mem2[0], mem2[1], mem2[2]); end
   endtask

   task automatic test_abort();
      int seen, dcnt;
      seen = 0; dcnt = 0;
      load_mem();
      @(negedge in_clk); start = 1'b1;
      @(negedge in_clk); start = 1'b0;
      for (int c = 0; c < 60 && seen == 0; c++) begin
         if (elem == 3'd2) seen = 1;
         else @(negedge in_clk);
      end
      total++; if (seen != 1) begin bad++; $display("FAIL abort_reach_elem2 got=%0d want=1", seen); end
      abort = 1'b1;
      @(negedge in_clk); abort = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
      total++; if ({cs, we, oe} !== 3'b0) begin bad++; $display("FAIL abort_ram_ctrl got=%b want=000", {cs, we, oe}); end
      total++; if (success !== 1'b0) begin bad++; $display("FAIL abort_success got=%b want=0", success); end
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1) dcnt++;
         @(negedge in_clk);
      end
      total++; if (dcnt != 0 || busy !== 1'b0) begin bad++;
         $display("FAIL abort_no_done got done_cycles=%0d busy=%b want=0 0", dcnt, busy); end
   endtask

   task automatic test_reset_midrun();
      int seen, dcyc, dcnt;
      seen = 0;
      load_mem();
      @(negedge in_clk); start = 1'b1;
      @(negedge in_clk); start = 1'b0;
      for (int c = 0; c < 60 && seen == 0; c++) begin
         if (elem == 3'd3 && we == 1'b1) seen = 1;
         else @(negedge in_clk);
      end
      total++; if (seen != 1) begin bad++; $display("FAIL rstmid_reach_m3wr got=%0d want=1", seen); end
      reset_n = 1'b0;
      #1;
      total++; if ({busy, done, success, cs, we, oe} !== 6'b0 || signature !== 3'd0 || elem !== 3'd0
                   || addr !== 2'd0 || data !== 3'd0) begin bad++;
         $display("FAIL rstmid_outputs got ctrl=%b sig=%0d elem=%0d addr=%0d data=%0d want all 0",
                  {busy, done, success, cs, we, oe}, signature, elem, addr, data); end
      @(negedge in_clk); reset_n = 1'b1;
      load_mem();
      run_a(43, dcyc, dcnt);
      total++; if (dcyc != 42) begin bad++; $display("FAIL rstmid_restart_cycle got=%0d want=42", dcyc); end
      total++; if (success !== 1'b1 || signature !== 3'b100) begin bad++;
         $display("FAIL rstmid_restart_result got success=%b sig=%b want=1 100", success, signature); end
   endtask

   task automatic test_start_while_busy();
      int dcyc, dcnt, inj;
      dcyc = -1; dcnt = 0; inj = 0;
      load_mem();
      @(negedge in_clk); start = 1'b1;
      @(negedge in_clk); start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (done === 1'b1) begin
            dcnt++;
            if (dcyc < 0) dcyc = c;
         end
         if (start) start = 1'b0;
         else if (inj == 0 && elem == 3'd1) begin start = 1'b1; inj = 1; end
         @(negedge in_clk);
      end
      total++; if (dcyc != 42) begin bad++; $display("FAIL busy_start_done_cycle got=%0d want=42", dcyc); end
      total++; if (dcnt != 1) begin bad++; $display("FAIL busy_start_pulses got=%0d want=1", dcnt); end
      total++; if (busy !== 1'b0 || success !== 1'b1) begin bad++;
         $display("FAIL busy_start_end got busy=%b success=%b want=0 1", busy, success); end
   endtask

   task automatic test_back_to_back();
      int d1, d2, dcnt;
      logic b43, s43, b44, s44;
      d1 = -1; d2 = -1; dcnt = 0;
      b43 = 1'b0; s43 = 1'b0; b44 = 1'b0; s44 = 1'b0;
      load_mem();
      @(negedge in_clk); start = 1'b1;
      for (int c = 1; c <= 86; c++) begin
         @(negedge in_clk);
         if (c == 44) start = 1'b0;
         if (c == 43) begin b43 = busy; s43 = success; end
         if (c == 44) begin b44 = busy; s44 = success; end
         if (done === 1'b1) begin
            dcnt++;
            if (d1 < 0) d1 = c;
            else if (d2 < 0) d2 = c;
         end
      end
      total++; if (d1 != 42 || d2 != 85 || dcnt != 2) begin bad++;
         $display("FAIL b2b_done got first=%0d second=%0d count=%0d want=42 85 2", d1, d2, dcnt); end
      total++; if (b43 !== 1'b0 || s43 !== 1'b1) begin bad++;
         $display("FAIL b2b_idle_gap got busy=%b success=%b want=0 1", b43, s43); end
      total++; if (b44 !== 1'b1 || s44 !== 1'b0) begin bad++;
         $display("FAIL b2b_reinit got busy=%b success=%b want=1 0", b44, s44); end
      total++; if (success !== 1'b1 || signature !== 3'b100) begin bad++;
         $display("FAIL b2b_second_result got success=%b sig=%b want=1 100", success, signature); end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; abort = 1'b0;
      start2 = 1'b0; abort2 = 1'b0; stuck_en = 1'b0;
      load_mem();
      mem2[0] = 3'd0; mem2[1] = 3'd0; mem2[2] = 3'd0;
      test_reset();
      test_stuck_at();
      test_full_run();
      test_partial_depth();
      test_abort();
      test_reset_midrun();
      test_start_while_busy();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
